// File: rtl/mips_mem_responder_pkg.sv
// Shared constants for the MIPS memory responder: FSM state codes,
// the all-lanes byte-enable value and the request address check.
package mips_mem_responder_pkg;

  localparam logic [1:0] MEM_IDLE   = 2'd0;
  localparam logic [1:0] MEM_WAIT   = 2'd1;
  localparam logic [1:0] MEM_ACCESS = 2'd2;
  localparam logic [1:0] MEM_RESP   = 2'd3;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // A request is bad when it is not word aligned or addresses beyond the RAM.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the multicycle control FSM (master)
// and the memory responder (slave).
interface mips_mem_responder_if #(
  parameter int N = 32
);
  logic         req_valid;
  logic         req_write;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic [3:0]   req_be;
  logic         busy;
  logic         resp_ready;
  logic [N-1:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  busy, resp_ready, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output busy, resp_ready, resp_rdata, resp_err
  );
endinterface

// File: rtl/mips_mem_responder_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// The read port is registered and returns the pre-write word on a store.
module mem_word_ram #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [N-1:0]      wdata,
  output logic [N-1:0]      rdata
);

  logic [N-1:0] mem [2**ADDR_W];

  // Read-before-write access with byte-lane masking on stores.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS datapath: accepts one
// request, waits WAIT_CYCLES, accesses the word RAM and pulses resp_ready.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int N           = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [N-1:0]      wdata_q;
  logic [3:0]        be_q;
  logic              err_q;
  logic              zero_q;
  logic [N-1:0]      ram_rdata;

  // zero_q forces resp_rdata to 0 after reset and for bad requests; it only
  // changes on the edge entering RESP so resp_rdata holds between completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MEM_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            waddr_q <= bus.req_addr[ADDR_W+1:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            if (addr_bad(bus.req_addr, ADDR_W)) begin
              err_q  <= 1'b1;
              zero_q <= 1'b1;
              state  <= MEM_RESP;
            end else begin
              err_q <= 1'b0;
              if (WAIT_CYCLES == 0) begin
                state <= MEM_ACCESS;
              end else begin
                cnt   <= WAIT_LOAD;
                state <= MEM_WAIT;
              end
            end
          end
        end
        MEM_WAIT: begin
          if (cnt == 4'd0) state <= MEM_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        MEM_ACCESS: begin
          zero_q <= 1'b0;
          state  <= MEM_RESP;
        end
        default: begin
          err_q <= 1'b0;
          state <= MEM_IDLE;
        end
      endcase
    end
  end

  // Response outputs decoded from the FSM state and result flags.
  always_comb begin
    bus.busy       = (state != MEM_IDLE);
    bus.resp_ready = (state == MEM_RESP);
    bus.resp_err   = err_q;
    bus.resp_rdata = zero_q ? '0 : ram_rdata;
  end

  mem_word_ram #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (state == MEM_ACCESS),
    .we    (wr_q),
    .addr  (waddr_q),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed scenarios plus
// random traffic checked against a word-array reference model.
module tb_mips_mem_responder;

  localparam int N     = 32;
  localparam int AW    = 10;
  localparam int WAITC = 2;
  localparam int WORDS = 2**AW;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] model [WORDS];

  mips_mem_responder_if #(.N(N)) bus  ();
  mips_mem_responder_if #(.N(N)) bus0 ();

  mips_mem_responder #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(WAITC)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  mips_mem_responder #(.N(N), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete request on the WAIT_CYCLES=2 responder, checked against the model.
  // Latency n counts edges after the accept edge until resp_ready is seen:
  // cycle t+k of the response rule starts at edge t+k-1.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic chg, input logic [31:0] alt);
    logic        is_bad;
    int          word;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          n;
    is_bad  = (a % 4 != 0) || (a >= 4 * WORDS);
    word    = is_bad ? 0 : int'(a / 4);
    exp_rd  = is_bad ? 32'd0 : model[word];
    exp_lat = is_bad ? 0 : WAITC + 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk); #1;
    if (chg) begin
      bus.req_addr  = alt;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
      bus.req_write = ~w;
    end
    n = 0;
    while (bus.resp_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rdata", bus.resp_rdata, exp_rd);
    chk("err", 32'(bus.resp_err), 32'(is_bad));
    if (!is_bad && w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[word][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("single_pulse", 32'(bus.resp_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = '0;
    bus.req_wdata = '0;    bus.req_be    = '0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0;   bus0.req_be    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.resp_ready), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill the low 64 words so every later read has a known value.
    for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom, 4'b1111, 1'b0, 32'd0);

    // Full store then load, byte-masked store then load.
    txn(1'b1, 32'h40, 32'h12345678, 4'b1111, 1'b0, 32'd0);
    txn(1'b0, 32'h40, 32'd0, 4'b0000, 1'b0, 32'd0);
    chk("word40_full", model[16], 32'h12345678);
    txn(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, 32'd0);
    txn(1'b0, 32'h40, 32'd0, 4'b0000, 1'b0, 32'd0);
    chk("word40_masked", model[16], 32'h12BB56DD);

    // Bad requests: misaligned, out of range, and a bad store that must not write.
    txn(1'b0, 32'h41, 32'd0, 4'b0000, 1'b0, 32'd0);
    txn(1'b0, 32'h00001000, 32'd0, 4'b0000, 1'b0, 32'd0);
    txn(1'b1, 32'h42, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'd0);
    txn(1'b1, 32'h00001040, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'd0);
    txn(1'b0, 32'h40, 32'd0, 4'b0000, 1'b0, 32'd0);

    // Reset in the middle of WAIT for a store to 0x10: nothing committed, no pulse.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hDEADBEEF; bus.req_be = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("midrst_ready", 32'(bus.resp_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 32'd0);

    // Request fields changed while busy are ignored.
    txn(1'b0, 32'h40, 32'd0, 4'b0000, 1'b1, 32'h80);
    txn(1'b1, 32'h44, 32'h0BADF00D, 4'b0011, 1'b1, 32'h88);
    txn(1'b0, 32'h44, 32'd0, 4'b0000, 1'b0, 32'd0);

    // Random traffic over the known region with occasional bad addresses.
    for (int i = 0; i < 150; i++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 63)) * 32'd4;
      if (kind == 0)      a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = a | (32'd1 << $urandom_range(12, 31));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), $urandom);
    end

    // Zero-wait responder with req_valid held: accept, ACCESS, RESP, IDLE repeating.
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h8;
    bus0.req_wdata = 32'hCAFEF00D; bus0.req_be = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("b2b_ready", 32'(bus0.resp_ready), 32'(k % 3 == 1));
      chk("b2b_busy", 32'(bus0.busy), 32'(k % 3 != 2));
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    chk("w0_ready", 32'(bus0.resp_ready), 32'd1);
    chk("w0_rdata", bus0.resp_rdata, 32'hCAFEF00D);
    chk("w0_err", 32'(bus0.resp_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
